// File: rtl/e203_wfi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// e203_wfi_pkg : state encoding and defaults for the WFI sequencer
// Rev 1.0
// ---------------------------------------------------------------
package e203_wfi_pkg;

  typedef enum logic [1:0] {
    WFI_IDLE  = 2'd0,
    WFI_DRAIN = 2'd1,
    WFI_SLEEP = 2'd2,
    WFI_WAKE  = 2'd3
  } wfi_state_e;

  localparam int WFI_WAKE_DLY_DEF = 2;
  localparam int WFI_CNT_W_DEF    = 4;

endpackage
`default_nettype wire

// File: rtl/e203_wfi_wake_cnt.sv
`default_nettype none
// ---------------------------------------------------------------
// e203_wfi_wake_cnt : loadable down-counter timing the WAKE state
// Rev 1.0
// ---------------------------------------------------------------
module e203_wfi_wake_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Saturates at zero so a stray dec never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  sirv_gnrl_dffr #(.DW(CNT_W)) u_cnt_dff (
    .dnxt  (cnt_d),
    .qout  (cnt_q),
    .clk   (clk),
    .rst_n (rst_n)
  );

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/sirv_gnrl_dffr.sv
`default_nettype none
// ---------------------------------------------------------------
// sirv_gnrl_dffr : general flop, async active-low reset to zero
// Rev 1.0
// ---------------------------------------------------------------
module sirv_gnrl_dffr #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= '0;
    end else begin
      qout <= dnxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/e203_wfi_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------
// e203_wfi_ctrl : WFI sleep/wake sequencer on the always-on clock
// Rev 1.0
// ---------------------------------------------------------------
module e203_wfi_ctrl
  import e203_wfi_pkg::*;
#(
  parameter int WAKE_DLY = WFI_WAKE_DLY_DEF,
  parameter int CNT_W    = WFI_CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wfi_req,
  input  logic       ifu_idle,
  input  logic       lsu_idle,
  input  logic       biu_idle,
  input  logic       oitf_empty,
  input  logic       irq_pend,
  input  logic       dbg_halt_req,
  output logic       halt_ifu,
  output logic       core_wfi,
  output logic       wfi_ack,
  output logic       wake_done,
  output logic [1:0] wfi_state
);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_DLY);

  wfi_state_e state_d;
  wfi_state_e state_q;
  logic [1:0] state_raw_q;

  logic wake_evt;
  logic all_idle;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  logic halt_ifu_d;
  logic core_wfi_d;
  logic wfi_ack_d;
  logic wake_done_d;
  logic halt_ifu_q;
  logic core_wfi_q;
  logic wfi_ack_q;
  logic wake_done_q;

  assign wake_evt = irq_pend | dbg_halt_req;
  assign all_idle = ifu_idle & lsu_idle & biu_idle & oitf_empty;
  assign state_q  = wfi_state_e'(state_raw_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      WFI_IDLE:  if (wfi_req) state_d = WFI_DRAIN;
      // A wake event during drain aborts the WFI ahead of drain completion.
      WFI_DRAIN: begin
        if (wake_evt) begin
          state_d = WFI_WAKE;
        end else if (all_idle) begin
          state_d = WFI_SLEEP;
        end
      end
      WFI_SLEEP: if (wake_evt) state_d = WFI_WAKE;
      WFI_WAKE:  if (cnt_zero) state_d = WFI_IDLE;
      default:   state_d = WFI_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so none of
  // them has a combinational path from the inputs.
  always_comb begin
    cnt_load    = (state_q != WFI_WAKE) && (state_d == WFI_WAKE);
    cnt_dec     = (state_q == WFI_WAKE);
    halt_ifu_d  = (state_d != WFI_IDLE);
    core_wfi_d  = (state_d == WFI_SLEEP);
    wfi_ack_d   = (state_q == WFI_DRAIN) && (state_d != WFI_DRAIN);
    wake_done_d = (state_q == WFI_WAKE) && (state_d == WFI_IDLE);
  end

  e203_wfi_wake_cnt #(.CNT_W(CNT_W)) u_wake_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (WAKE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  sirv_gnrl_dffr #(.DW(2)) u_state_dff (
    .dnxt (state_d), .qout (state_raw_q), .clk (clk), .rst_n (rst_n)
  );
  sirv_gnrl_dffr #(.DW(1)) u_halt_ifu_dff (
    .dnxt (halt_ifu_d), .qout (halt_ifu_q), .clk (clk), .rst_n (rst_n)
  );
  // Dedicated bit feeding the clock-gate enable.
  sirv_gnrl_dffr #(.DW(1)) u_core_wfi_dff (
    .dnxt (core_wfi_d), .qout (core_wfi_q), .clk (clk), .rst_n (rst_n)
  );
  sirv_gnrl_dffr #(.DW(1)) u_wfi_ack_dff (
    .dnxt (wfi_ack_d), .qout (wfi_ack_q), .clk (clk), .rst_n (rst_n)
  );
  sirv_gnrl_dffr #(.DW(1)) u_wake_done_dff (
    .dnxt (wake_done_d), .qout (wake_done_q), .clk (clk), .rst_n (rst_n)
  );

  assign halt_ifu  = halt_ifu_q;
  assign core_wfi  = core_wfi_q;
  assign wfi_ack   = wfi_ack_q;
  assign wake_done = wake_done_q;
  assign wfi_state = state_raw_q;

endmodule
`default_nettype wire

// File: tb/tb_e203_wfi_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_e203_wfi_ctrl : directed vector bench for the WFI sequencer
// Rev 1.0
// ---------------------------------------------------------------
module tb_e203_wfi_ctrl;

  // Expected output vector: {halt_ifu, core_wfi, wfi_ack, wake_done, wfi_state}
  localparam logic [5:0] E_IDLE      = 6'b000000;
  localparam logic [5:0] E_IDLE_DONE = 6'b000100;
  localparam logic [5:0] E_DRAIN     = 6'b100001;
  localparam logic [5:0] E_SLEEP_ACK = 6'b111010;
  localparam logic [5:0] E_SLEEP     = 6'b110010;
  localparam logic [5:0] E_WAKE      = 6'b100011;
  localparam logic [5:0] E_WAKE_ACK  = 6'b101011;
  localparam logic [3:0] ALL = 4'b1111;
  localparam logic [3:0] LSB = 4'b1011;  // lsu busy

  typedef struct packed {
    logic       req;
    logic [3:0] idle;  // {ifu, lsu, biu, oitf}
    logic       irq;
    logic       dbg;
    logic [5:0] exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       wfi_req;
  logic [3:0] idle;
  logic       irq_pend;
  logic       dbg_halt_req;
  logic       req0;
  logic       irq0;

  logic       halt_ifu, core_wfi, wfi_ack, wake_done;
  logic [1:0] wfi_state;
  logic       halt0, wfi0, ack0, done0;
  logic [1:0] state0;

  logic [5:0] outs;
  logic [5:0] outs0;

  int n_checks;
  int n_errors;
  vec_t vecs[$];

  assign outs  = {halt_ifu, core_wfi, wfi_ack, wake_done, wfi_state};
  assign outs0 = {halt0, wfi0, ack0, done0, state0};

  e203_wfi_ctrl #(.WAKE_DLY(2), .CNT_W(4)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wfi_req      (wfi_req),
    .ifu_idle     (idle[3]),
    .lsu_idle     (idle[2]),
    .biu_idle     (idle[1]),
    .oitf_empty   (idle[0]),
    .irq_pend     (irq_pend),
    .dbg_halt_req (dbg_halt_req),
    .halt_ifu     (halt_ifu),
    .core_wfi     (core_wfi),
    .wfi_ack      (wfi_ack),
    .wake_done    (wake_done),
    .wfi_state    (wfi_state)
  );

  e203_wfi_ctrl #(.WAKE_DLY(0), .CNT_W(4)) u_dut_d0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .wfi_req      (req0),
    .ifu_idle     (1'b1),
    .lsu_idle     (1'b1),
    .biu_idle     (1'b1),
    .oitf_empty   (1'b1),
    .irq_pend     (irq0),
    .dbg_halt_req (1'b0),
    .halt_ifu     (halt0),
    .core_wfi     (wfi0),
    .wfi_ack      (ack0),
    .wake_done    (done0),
    .wfi_state    (state0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] id, input logic i,
                              input logic d, input logic [5:0] e);
    vec_t v;
    v.req  = r;
    v.idle = id;
    v.irq  = i;
    v.dbg  = d;
    v.exp  = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, compare just after the rising edge.
  task automatic step(input logic r, input logic [3:0] id, input logic i, input logic d,
                      input logic [5:0] e, input string name);
    @(negedge clk);
    wfi_req      = r;
    idle         = id;
    irq_pend     = i;
    dbg_halt_req = d;
    @(posedge clk);
    #1;
    chk(name, outs, e);
  endtask

  task automatic step0(input logic r, input logic i, input logic [5:0] e, input string name);
    @(negedge clk);
    req0 = r;
    irq0 = i;
    @(posedge clk);
    #1;
    chk(name, outs0, e);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(name, outs, E_IDLE);
    @(posedge clk);
    #1;
    chk({name, "_held"}, outs, E_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    wfi_req      = 1'b0;
    idle         = ALL;
    irq_pend     = 1'b0;
    dbg_halt_req = 1'b0;
    req0         = 1'b0;
    irq0         = 1'b0;

    // Basic sleep/wake, lsu activity during SLEEP is ignored
    vecs.push_back(mk(0, ALL, 0, 0, E_IDLE));
    vecs.push_back(mk(1, ALL, 0, 0, E_DRAIN));
    vecs.push_back(mk(1, ALL, 0, 0, E_SLEEP_ACK));
    for (int c = 2; c <= 9; c++) begin
      vecs.push_back(mk(0, (c >= 5 && c <= 7) ? LSB : ALL, 0, 0, E_SLEEP));
    end
    vecs.push_back(mk(0, ALL, 1, 0, E_WAKE));
    vecs.push_back(mk(0, ALL, 0, 0, E_WAKE));
    vecs.push_back(mk(0, ALL, 0, 0, E_WAKE));
    vecs.push_back(mk(0, ALL, 0, 0, E_IDLE_DONE));
    vecs.push_back(mk(0, ALL, 0, 0, E_IDLE));
    // Drain wait: lsu busy until c7
    for (int c = 0; c <= 6; c++) begin
      vecs.push_back(mk(1, LSB, 0, 0, E_DRAIN));
    end
    vecs.push_back(mk(1, ALL, 0, 0, E_SLEEP_ACK));
    vecs.push_back(mk(0, ALL, 0, 1, E_WAKE));
    vecs.push_back(mk(0, ALL, 0, 1, E_WAKE));
    vecs.push_back(mk(0, ALL, 0, 1, E_WAKE));
    vecs.push_back(mk(0, ALL, 0, 0, E_IDLE_DONE));
    vecs.push_back(mk(0, ALL, 0, 0, E_IDLE));
    // Abort in DRAIN via debug request
    vecs.push_back(mk(1, LSB, 0, 0, E_DRAIN));
    vecs.push_back(mk(1, LSB, 0, 0, E_DRAIN));
    vecs.push_back(mk(1, LSB, 0, 0, E_DRAIN));
    vecs.push_back(mk(1, LSB, 0, 1, E_WAKE_ACK));
    vecs.push_back(mk(0, LSB, 0, 0, E_WAKE));
    vecs.push_back(mk(0, LSB, 0, 0, E_WAKE));
    vecs.push_back(mk(0, LSB, 0, 0, E_IDLE_DONE));
    // Back-to-back WFI; req held through SLEEP gives a single ack
    vecs.push_back(mk(1, ALL, 0, 0, E_DRAIN));
    vecs.push_back(mk(1, ALL, 0, 0, E_SLEEP_ACK));
    vecs.push_back(mk(1, ALL, 0, 0, E_SLEEP));
    vecs.push_back(mk(1, ALL, 0, 0, E_SLEEP));
    vecs.push_back(mk(0, ALL, 1, 0, E_WAKE));
    vecs.push_back(mk(0, ALL, 0, 0, E_WAKE));
    vecs.push_back(mk(0, ALL, 0, 0, E_WAKE));
    vecs.push_back(mk(0, ALL, 0, 0, E_IDLE_DONE));
    // Wake event already pending when req arrives: WFI acts as a NOP
    vecs.push_back(mk(1, ALL, 1, 0, E_DRAIN));
    vecs.push_back(mk(0, ALL, 1, 0, E_WAKE_ACK));
    vecs.push_back(mk(0, ALL, 1, 0, E_WAKE));
    vecs.push_back(mk(0, ALL, 1, 0, E_WAKE));
    vecs.push_back(mk(0, ALL, 1, 0, E_IDLE_DONE));
    vecs.push_back(mk(0, ALL, 0, 0, E_IDLE));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", outs, E_IDLE);
    chk("reset_state_d0", outs0, E_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      step(vecs[k].req, vecs[k].idle, vecs[k].irq, vecs[k].dbg, vecs[k].exp,
           $sformatf("vec%0d", k));
    end

    // Reset in the middle of SLEEP, then a normal cycle
    step(1, ALL, 0, 0, E_DRAIN, "rs_drain");
    step(0, ALL, 0, 0, E_SLEEP_ACK, "rs_sleep");
    step(0, ALL, 0, 0, E_SLEEP, "rs_sleep2");
    async_reset("rst_in_sleep");
    for (int c = 0; c < 3; c++) begin
      step(0, ALL, 0, 0, E_IDLE, $sformatf("rs_post%0d", c));
    end
    step(1, ALL, 0, 0, E_DRAIN, "rs_again_drain");
    step(0, ALL, 0, 0, E_SLEEP_ACK, "rs_again_sleep");
    step(0, ALL, 1, 0, E_WAKE, "rs_again_wake");

    // Reset in the middle of WAKE: no wake_done afterwards
    async_reset("rst_in_wake");
    for (int c = 0; c < 4; c++) begin
      step(0, ALL, 0, 0, E_IDLE, $sformatf("rw_post%0d", c));
    end
    step(1, ALL, 0, 0, E_DRAIN, "rw_again_drain");
    step(0, ALL, 0, 0, E_SLEEP_ACK, "rw_again_sleep");

    // WAKE_DLY=0 instance: single WAKE cycle
    step0(1, 0, E_DRAIN, "d0_drain");
    step0(0, 0, E_SLEEP_ACK, "d0_sleep_ack");
    step0(0, 0, E_SLEEP, "d0_sleep");
    step0(0, 1, E_WAKE, "d0_wake");
    step0(0, 0, E_IDLE_DONE, "d0_done");
    step0(0, 0, E_IDLE, "d0_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
